eth_tx_noc_in_mc: RTL
=====================

# eth_tx_noc_in_mc

Multi-channel, parametrised NoC-to-Ethernet TX front end for the Ethernet TX tile. It accepts up to `NUM_CH` independent NoC input channels and arbitrates between them round-robin at packet granularity. For each packet it parses a NoC header flit and a metadata flit, then emits an Ethernet header handshake followed by a payload stream with `last` and pad-byte marking for the downstream to-stream stage. Beat count and pad bytes come from the payload length, and it logs per-packet start timestamps together with the source channel.

## Interface
Parameters:
- `NUM_CH`, 2: number of NoC input channels (≥1).
- `NOC_W`, 512: NoC flit width; must equal `MAC_W` and be ≥ 192.
- `MAC_W`, 512: MAC data width; a power of two, ≥ 64.
- `LEN_W`, 16: payload length width, in bytes.
- `TS_W`, 64: timestamp width.
- Derived: `MAC_B = MAC_W/8`; `PAD_W = $clog2(MAC_B)`; `CH_W = max(1,$clog2(NUM_CH))`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `noc_in_val`  in  NUM_CH  per-channel flit valid.
- `noc_in_data`  in  NUM_CH*NOC_W  per-channel flit; channel i occupies `[i*NOC_W +: NOC_W]`.
- `noc_in_rdy`  out  NUM_CH  per-channel flit ready.
- `eth_hdr_val`  out  1  Ethernet header valid.
- `eth_hdr`  out  112  {dst MAC[111:64], src MAC[63:16], ethertype[15:0]}.
- `eth_payload_len`  out  LEN_W  payload bytes.
- `eth_hdr_rdy`  in  1  header ready.
- `data_val`  out  1  payload beat valid.
- `data`  out  MAC_W  payload beat.
- `data_last`  out  1  final beat of the packet.
- `data_padbytes`  out  PAD_W  invalid trailing bytes in the final beat; 0 on all other beats.
- `data_rdy`  in  1  payload ready.
- `eth_wr_log`  out  1  one-cycle pulse when a packet completes.
- `eth_wr_log_start_timestamp`  out  TS_W  timestamp of the current or most recent packet.
- `eth_wr_log_chan`  out  CH_W  channel of the current or most recent packet.

## Operation
- Flit format:
  - Flit 0 is the NoC header; its contents are ignored.
  - Flit 1 is metadata: `[111:0]` = eth_hdr, `[112 +: LEN_W]` = payload_len, `[112+LEN_W +: TS_W]` = timestamp. The fields are packed contiguously; the `NOC_W` ≥ 192 bound assumes `LEN_W`+`TS_W` ≤ 80 (true for the defaults).
  - Then `ceil(len/MAC_B)` data flits follow; there are none when len = 0.
- FSM states:
  - `ARB`: if any `noc_in_val`, register `grant` = first valid channel at or after `rr_ptr` (cyclic), then go to `HDR`. Nothing is consumed in this state.
  - `HDR`: `noc_in_rdy[grant]`=1. On val, discard the flit and go to `META`.
  - `META`: `noc_in_rdy[grant]`=1. On val, capture hdr, len and timestamp; load `beats_left = ceil(len/MAC_B)`; update the log timestamp and chan; go to `HDR_OUT`.
  - `HDR_OUT`: `eth_hdr_val`=1. On `eth_hdr_rdy`, go to `DATA` if `beats_left`≠0. Otherwise pulse `eth_wr_log`, set `rr_ptr=grant+1 mod NUM_CH`, and go to `ARB`.
  - `DATA`: combinational pass-through. `data_val=noc_in_val[grant]`, `noc_in_rdy[grant]=data_rdy`, `data=noc_in_data[grant]`. `data_last` = (`beats_left`==1). On a handshake, decrement `beats_left`. On the last handshake, pulse `eth_wr_log` in the following cycle, advance `rr_ptr` as above, and go to `ARB`.
- `data_padbytes` on the last beat = `(MAC_B - len % MAC_B) % MAC_B`, computed at META capture.
- Non-granted channels see `noc_in_rdy`=0 in every state.
- Reset: state `ARB`, `rr_ptr`=0, `grant`=0, `beats_left`=0, and all outputs 0, including the log timestamp and chan.
- Reset asserted mid-packet aborts the packet immediately. The remaining upstream flits are the sender's responsibility.

## Timing
- Continuous input valid with ready downstream: flit 0 is consumed at cycle 1 (ARB at cycle 0), meta at cycle 2, and `eth_hdr_val` rises at cycle 3.
- The first data beat is accepted at cycle 4. Each subsequent beat takes 1 cycle when val and rdy are both held.
- Per-packet overhead is 4 cycles (ARB, HDR, META, HDR_OUT) plus beats. `eth_wr_log` is registered and asserts one cycle after the final handshake.
- `eth_hdr`, `eth_payload_len` and `eth_hdr_val` are stable while val is high and rdy is low. Data outputs follow the granted input combinationally.
- Round-robin: a channel that has just been served has the lowest priority in the next ARB. A channel that is continuously valid waits at most `NUM_CH-1` packets.

## Test plan
- Single packet, MAC_W=512, len=130 on ch0 -> hdr handshake with len=130; 3 beats; last on beat 3 with padbytes=62; `eth_wr_log` pulses once with chan=0.
- len=128 -> 2 beats, padbytes=0 on last. len=0 -> no data beats, log pulse follows the hdr handshake.
- Both channels continuously valid, 3 packets each -> output order ch0, ch1, ch0, ch1, ch0, ch1. `noc_in_rdy` is never high on the non-granted channel.
- Random `data_rdy` and `eth_hdr_rdy` stalls with input gaps -> payload identical to input, no beats dropped or duplicated, hdr fields stable throughout stalls.
- `rst` asserted during DATA beat 2 of 4 -> next cycle state is ARB, all outputs 0, `rr_ptr`=0. A fresh packet afterwards completes correctly.
- NUM_CH=4, only ch3 valid -> granted in the first ARB cycle; log chan=3; timestamp equals the meta value 0xDEADBEEF_00000001.

Source files
------------

// File: rtl/eth_tx_noc_in_mc.sv
// eth_tx_noc_in_mc
// Multi-channel NoC-to-Ethernet TX front end. Channels are arbitrated
// round-robin, one whole packet at a time. Each packet is a header flit
// (ignored), a metadata flit (Ethernet header, payload length, timestamp),
// then ceil(len/MAC_B) data flits passed straight through to the MAC side
// with last/pad-byte marking. Start timestamp and channel are logged per packet.
module eth_tx_noc_in_mc #(
    parameter int NUM_CH = 2,
    parameter int NOC_W  = 512,
    parameter int MAC_W  = 512,
    parameter int LEN_W  = 16,
    parameter int TS_W   = 64,
    localparam int MAC_B = MAC_W / 8,
    localparam int PAD_W = $clog2(MAC_B),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       noc_in_val,
    input  logic [NUM_CH*NOC_W-1:0] noc_in_data,
    output logic [NUM_CH-1:0]       noc_in_rdy,
    output logic                    eth_hdr_val,
    output logic [111:0]            eth_hdr,
    output logic [LEN_W-1:0]        eth_payload_len,
    input  logic                    eth_hdr_rdy,
    output logic                    data_val,
    output logic [MAC_W-1:0]        data,
    output logic                    data_last,
    output logic [PAD_W-1:0]        data_padbytes,
    input  logic                    data_rdy,
    output logic                    eth_wr_log,
    output logic [TS_W-1:0]         eth_wr_log_start_timestamp,
    output logic [CH_W-1:0]         eth_wr_log_chan
);

    typedef enum logic [2:0] {
        ARB     = 3'd0,
        HDR     = 3'd1,
        META    = 3'd2,
        HDR_OUT = 3'd3,
        DATA    = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   grant_reg, grant_next;
    logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]  beats_left_reg, beats_left_next;
    logic [111:0]      hdr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [PAD_W-1:0]  pad_reg;
    logic [TS_W-1:0]   log_ts_reg;
    logic [CH_W-1:0]   log_chan_reg;
    logic              log_reg, log_next;
    logic              meta_load;

    // Per-channel flit view and the granted channel's handshake signals
    logic [NOC_W-1:0]  ch_data [NUM_CH];
    logic [NOC_W-1:0]  sel_data;
    logic              sel_val;
    logic              sel_rdy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_data[gi]    = noc_in_data[gi*NOC_W +: NOC_W];
            // Only the granted channel ever sees ready
            assign noc_in_rdy[gi] = (grant_reg == CH_W'(gi)) && sel_rdy;
        end
    endgenerate

    assign sel_data = ch_data[grant_reg];
    assign sel_val  = noc_in_val[grant_reg];

    // Metadata fields, packed contiguously above the 112-bit Ethernet header
    logic [111:0]      meta_hdr;
    logic [LEN_W-1:0]  meta_len;
    logic [TS_W-1:0]   meta_ts;
    logic [LEN_W:0]    len_round;
    logic [LEN_W-1:0]  beats_calc;
    logic [PAD_W-1:0]  pad_calc;

    assign meta_hdr   = sel_data[111:0];
    assign meta_len   = sel_data[112 +: LEN_W];
    assign meta_ts    = sel_data[112+LEN_W +: TS_W];
    // One extra bit so rounding up a near-maximal length cannot wrap
    assign len_round  = {1'b0, meta_len} + (LEN_W+1)'(MAC_B - 1);
    assign beats_calc = LEN_W'(len_round >> PAD_W);
    // (MAC_B - len % MAC_B) % MAC_B is the two's complement of the low bits
    assign pad_calc   = ~meta_len[PAD_W-1:0] + PAD_W'(1);

    // Channel after the granted one, wrapping; the served channel drops to lowest priority
    logic [CH_W-1:0] grant_inc;
    assign grant_inc = (grant_reg == CH_W'(NUM_CH - 1)) ? '0 : grant_reg + CH_W'(1);

    // Round-robin search: first valid channel at or after rr_ptr, cyclically
    logic            arb_found;
    logic [CH_W-1:0] arb_pick;
    logic [CH_W:0]   arb_idx;
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx = {1'b0, rr_ptr_reg} + (CH_W+1)'(k);
            if (arb_idx >= (CH_W+1)'(NUM_CH)) begin
                arb_idx = arb_idx - (CH_W+1)'(NUM_CH);
            end
            if (!arb_found && noc_in_val[arb_idx[CH_W-1:0]]) begin
                arb_found = 1'b1;
                arb_pick  = arb_idx[CH_W-1:0];
            end
        end
    end

    // Next-state logic and all combinational handshake/data outputs
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        rr_ptr_next     = rr_ptr_reg;
        beats_left_next = beats_left_reg;
        meta_load       = 1'b0;
        log_next        = 1'b0;
        sel_rdy         = 1'b0;
        eth_hdr_val     = 1'b0;
        data_val        = 1'b0;
        data            = '0;
        data_last       = 1'b0;
        data_padbytes   = '0;
        case (state_reg)
            ARB: begin
                if (arb_found) begin
                    grant_next = arb_pick;
                    state_next = HDR;
                end
            end
            HDR: begin
                sel_rdy = 1'b1;
                if (sel_val) begin
                    state_next = META;
                end
            end
            META: begin
                sel_rdy = 1'b1;
                if (sel_val) begin
                    meta_load       = 1'b1;
                    beats_left_next = beats_calc;
                    state_next      = HDR_OUT;
                end
            end
            HDR_OUT: begin
                eth_hdr_val = 1'b1;
                if (eth_hdr_rdy) begin
                    if (beats_left_reg != '0) begin
                        state_next = DATA;
                    end else begin
                        log_next    = 1'b1;
                        rr_ptr_next = grant_inc;
                        state_next  = ARB;
                    end
                end
            end
            DATA: begin
                sel_rdy       = data_rdy;
                data_val      = sel_val;
                data          = sel_data[MAC_W-1:0];
                data_last     = (beats_left_reg == LEN_W'(1));
                data_padbytes = data_last ? pad_reg : '0;
                if (sel_val && data_rdy) begin
                    beats_left_next = beats_left_reg - LEN_W'(1);
                    if (data_last) begin
                        log_next    = 1'b1;
                        rr_ptr_next = grant_inc;
                        state_next  = ARB;
                    end
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // Control state: FSM, grant, round-robin pointer, beat counter, log pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ARB;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            beats_left_reg <= '0;
            log_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            beats_left_reg <= beats_left_next;
            log_reg        <= log_next;
        end
    end

    // Metadata capture; held until the next packet's metadata arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg      <= '0;
            len_reg      <= '0;
            pad_reg      <= '0;
            log_ts_reg   <= '0;
            log_chan_reg <= '0;
        end else if (meta_load) begin
            hdr_reg      <= meta_hdr;
            len_reg      <= meta_len;
            pad_reg      <= pad_calc;
            log_ts_reg   <= meta_ts;
            log_chan_reg <= grant_reg;
        end
    end

    assign eth_hdr                    = hdr_reg;
    assign eth_payload_len            = len_reg;
    assign eth_wr_log                 = log_reg;
    assign eth_wr_log_start_timestamp = log_ts_reg;
    assign eth_wr_log_chan            = log_chan_reg;

endmodule
